// File: rtl/timer_a_counter.sv
// Timer_A counter core: clock-source select, two-stage prescaler, TAR counter with
// stop/up/continuous/up-down modes, and the TAIFG overflow flag.
module timer_a_counter #(
  parameter int TAR_W = 16
) (
  input  logic             MCLK,
  input  logic             reset,
  input  logic [1:0]       TASSEL,
  input  logic             TACLKen,
  input  logic             ACLKen,
  input  logic             SMCLKen,
  input  logic             INCLKen,
  input  logic [1:0]       ID,
  input  logic [2:0]       TAIDEX,
  input  logic [1:0]       MC,
  input  logic             TACLR,
  input  logic [TAR_W-1:0] TAxCCR0,
  input  logic             TARwrite,
  input  logic [TAR_W-1:0] TARin,
  input  logic             TAIFGclr,
  input  logic             TAIFGwr,
  input  logic             TAIFGwdata,
  output logic [TAR_W-1:0] TAR,
  output logic             TAdir,
  output logic             TAcount,
  output logic             wTAIFG
);

  localparam logic [1:0] MC_STOP = 2'b00;
  localparam logic [1:0] MC_UP   = 2'b01;
  localparam logic [1:0] MC_CONT = 2'b10;
  localparam logic [1:0] MC_UPDN = 2'b11;

  logic [TAR_W-1:0] r_tar;
  logic             r_dir;
  logic             r_count;
  logic             r_ifg;
  logic [2:0]       r_div1;
  logic [2:0]       r_div2;

  logic             w_tick;
  logic             w_adv;
  logic [2:0]       w_div1Lim;
  logic             w_div1Emit;
  logic             w_event;
  logic [TAR_W-1:0] w_tarInc;
  logic [TAR_W-1:0] w_tarDec;
  logic             w_goDown;
  logic [TAR_W-1:0] w_nextTar;
  logic             w_nextDir;
  logic             w_setIfg;
  logic             w_counted;
  logic             w_hwSet;

  always_comb begin
    w_tick = TACLKen;
    case (TASSEL)
      2'b00:   w_tick = TACLKen;
      2'b01:   w_tick = ACLKen;
      2'b10:   w_tick = SMCLKen;
      default: w_tick = INCLKen;
    endcase
  end

  always_comb begin
    w_div1Lim = 3'd0;
    case (ID)
      2'b00:   w_div1Lim = 3'd0;
      2'b01:   w_div1Lim = 3'd1;
      2'b10:   w_div1Lim = 3'd3;
      default: w_div1Lim = 3'd7;
    endcase
  end

  // Terminal counts use >= so a divider lowered mid-count still wraps cleanly.
  assign w_adv      = w_tick && (MC != MC_STOP);
  assign w_div1Emit = w_adv && (r_div1 >= w_div1Lim);
  assign w_event    = w_div1Emit && (r_div2 >= TAIDEX);

  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      r_div1 <= 3'd0;
      r_div2 <= 3'd0;
    end else if (TACLR) begin
      r_div1 <= 3'd0;
      r_div2 <= 3'd0;
    end else if (w_adv) begin
      r_div1 <= (r_div1 >= w_div1Lim) ? 3'd0 : r_div1 + 3'd1;
      if (w_div1Emit)
        r_div2 <= (r_div2 >= TAIDEX) ? 3'd0 : r_div2 + 3'd1;
    end
  end

  assign w_tarInc = r_tar + TAR_W'(1);
  assign w_tarDec = r_tar - TAR_W'(1);
  // Up/down descends while flagged down (until 0) or when already at/above the period.
  assign w_goDown = r_dir ? (r_tar != '0) : (r_tar >= TAxCCR0);

  always_comb begin
    w_nextTar = r_tar;
    w_nextDir = r_dir;
    w_setIfg  = 1'b0;
    w_counted = 1'b0;
    if (w_event) begin
      w_counted = 1'b1;
      case (MC)
        MC_UP: begin
          w_nextDir = 1'b0;
          if (TAxCCR0 == '0) begin
            w_nextTar = '0;
            w_counted = 1'b0;
          end else if (r_tar >= TAxCCR0) begin
            w_nextTar = '0;
            w_setIfg  = 1'b1;
          end else begin
            w_nextTar = w_tarInc;
          end
        end
        MC_CONT: begin
          w_nextDir = 1'b0;
          w_nextTar = w_tarInc;
          w_setIfg  = &r_tar;
        end
        MC_UPDN: begin
          if (TAxCCR0 == '0) begin
            w_nextTar = '0;
            w_nextDir = 1'b0;
            w_counted = 1'b0;
          end else if (w_goDown) begin
            w_nextTar = w_tarDec;
            w_nextDir = (r_tar != TAR_W'(1));
            w_setIfg  = (r_tar == TAR_W'(1));
          end else begin
            w_nextTar = w_tarInc;
            w_nextDir = (w_tarInc == TAxCCR0);
          end
        end
        default: w_counted = 1'b0;
      endcase
    end
  end

  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      r_tar   <= '0;
      r_dir   <= 1'b0;
      r_count <= 1'b0;
    end else begin
      r_count <= 1'b0;
      if (TACLR) begin
        r_tar <= '0;
        r_dir <= 1'b0;
      end else if (TARwrite) begin
        r_tar <= TARin;
      end else begin
        r_tar   <= w_nextTar;
        r_dir   <= w_nextDir;
        r_count <= w_counted;
      end
    end
  end

  // A count event pre-empted by TACLR or a TAR write cannot raise the flag.
  assign w_hwSet = w_setIfg && !TACLR && !TARwrite;

  always_ff @(posedge MCLK or posedge reset) begin
    if (reset)
      r_ifg <= 1'b0;
    else if (w_hwSet)
      r_ifg <= 1'b1;
    else if (TAIFGwr)
      r_ifg <= TAIFGwdata;
    else if (TAIFGclr)
      r_ifg <= 1'b0;
  end

  assign TAR     = r_tar;
  assign TAdir   = r_dir;
  assign TAcount = r_count;
  assign wTAIFG  = r_ifg;

endmodule

// File: tb/tb_timer_a_counter.sv
// Self-checking bench for timer_a_counter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural reference model.
module tb_timer_a_counter;

  logic        MCLK;
  logic        reset;
  logic [1:0]  TASSEL;
  logic        TACLKen, ACLKen, SMCLKen, INCLKen;
  logic [1:0]  ID;
  logic [2:0]  TAIDEX;
  logic [1:0]  MC;
  logic        TACLR;
  logic [15:0] TAxCCR0;
  logic        TARwrite;
  logic [15:0] TARin;
  logic        TAIFGclr, TAIFGwr, TAIFGwdata;
  logic [15:0] TAR;
  logic        TAdir, TAcount, wTAIFG;

  int checks = 0;
  int failures = 0;
  bit cmpEn = 0;

  timer_a_counter #(.TAR_W(16)) dut (
    .MCLK(MCLK), .reset(reset), .TASSEL(TASSEL),
    .TACLKen(TACLKen), .ACLKen(ACLKen), .SMCLKen(SMCLKen), .INCLKen(INCLKen),
    .ID(ID), .TAIDEX(TAIDEX), .MC(MC), .TACLR(TACLR), .TAxCCR0(TAxCCR0),
    .TARwrite(TARwrite), .TARin(TARin), .TAIFGclr(TAIFGclr), .TAIFGwr(TAIFGwr),
    .TAIFGwdata(TAIFGwdata), .TAR(TAR), .TAdir(TAdir), .TAcount(TAcount), .wTAIFG(wTAIFG)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  // Reference state: the prescaler is one tick counter modulo the total divide ratio.
  typedef struct packed {
    logic [15:0] tar;
    logic        dir;
    logic        cnt;
    logic        ifg;
    logic [31:0] pre;
  } modelT;

  modelT m;

  function automatic modelT modelNext(modelT cur);
    modelT nx;
    logic  tick;
    logic  evt;
    logic  hwSet;
    int    period;
    nx = cur;
    nx.cnt = 1'b0;
    hwSet = 1'b0;
    evt = 1'b0;
    case (TASSEL)
      2'd0:    tick = TACLKen;
      2'd1:    tick = ACLKen;
      2'd2:    tick = SMCLKen;
      default: tick = INCLKen;
    endcase
    period = (1 << ID) * (int'(TAIDEX) + 1);
    if (TACLR) nx.pre = 0;
    else if (tick && MC != 2'd0) begin
      nx.pre = cur.pre + 1;
      if (int'(nx.pre) == period) begin
        evt = 1'b1;
        nx.pre = 0;
      end
    end
    if (TACLR) begin
      nx.tar = 16'd0;
      nx.dir = 1'b0;
    end else if (TARwrite) begin
      nx.tar = TARin;
    end else if (evt) begin
      nx.cnt = 1'b1;
      if (MC == 2'd2) begin
        nx.dir = 1'b0;
        hwSet = (cur.tar == 16'hFFFF);
        nx.tar = cur.tar + 16'd1;
      end else if (TAxCCR0 == 16'd0) begin
        nx.tar = 16'd0;
        nx.dir = 1'b0;
        nx.cnt = 1'b0;
      end else if (MC == 2'd1) begin
        nx.dir = 1'b0;
        if (cur.tar >= TAxCCR0) begin
          nx.tar = 16'd0;
          hwSet = 1'b1;
        end else nx.tar = cur.tar + 16'd1;
      end else if (cur.dir ? (cur.tar != 16'd0) : (cur.tar >= TAxCCR0)) begin
        nx.tar = cur.tar - 16'd1;
        nx.dir = (nx.tar != 16'd0);
        hwSet = (nx.tar == 16'd0);
      end else begin
        nx.tar = cur.tar + 16'd1;
        nx.dir = (nx.tar == TAxCCR0);
      end
    end
    if (hwSet) nx.ifg = 1'b1;
    else if (TAIFGwr) nx.ifg = TAIFGwdata;
    else if (TAIFGclr) nx.ifg = 1'b0;
    return nx;
  endfunction

  always @(posedge MCLK or posedge reset) begin
    if (reset) m <= '0;
    else m <= modelNext(m);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge MCLK) begin
    if (cmpEn) begin
      checkOutput("model_TAR", TAR, m.tar);
      checkOutput("model_TAdir", TAdir, m.dir);
      checkOutput("model_TAcount", TAcount, m.cnt);
      checkOutput("model_wTAIFG", wTAIFG, m.ifg);
    end
  end

  task automatic nextCycle();
    @(negedge MCLK);
    #1;
  endtask

  task automatic clearStrobes();
    TACLR = 0; TARwrite = 0; TAIFGclr = 0; TAIFGwr = 0; TAIFGwdata = 0;
  endtask

  task automatic applyStimulus();
    TASSEL = 2'($urandom_range(0, 3));
    TACLKen = ($urandom_range(0, 3) != 0);
    ACLKen = ($urandom_range(0, 3) != 0);
    SMCLKen = ($urandom_range(0, 3) != 0);
    INCLKen = ($urandom_range(0, 3) != 0);
    if ($urandom_range(0, 49) == 0) MC = 2'($urandom_range(0, 3));
    if ($urandom_range(0, 79) == 0) TAxCCR0 = 16'($urandom_range(0, 12));
    TACLR = ($urandom_range(0, 59) == 0);
    if (TACLR && $urandom_range(0, 1) == 1) begin
      ID = 2'($urandom_range(0, 3));
      TAIDEX = 3'($urandom_range(0, 7));
    end
    TARwrite = ($urandom_range(0, 39) == 0);
    TARin = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 15))
                                        : 16'hFFF0 + 16'($urandom_range(0, 15));
    TAIFGclr = ($urandom_range(0, 7) == 0);
    TAIFGwr = ($urandom_range(0, 15) == 0);
    TAIFGwdata = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int expT[5];
    int expD[5];
    int expF[5];
    reset = 1; TASSEL = 0; TACLKen = 0; ACLKen = 0; SMCLKen = 0; INCLKen = 0;
    ID = 0; TAIDEX = 0; MC = 0; TAxCCR0 = 0; TARin = 0;
    clearStrobes();
    cmpEn = 1;
    nextCycle();
    nextCycle();
    reset = 0;
    checkOutput("reset_TAR", TAR, 0);
    checkOutput("reset_TAdir", TAdir, 0);
    checkOutput("reset_TAcount", TAcount, 0);
    checkOutput("reset_wTAIFG", wTAIFG, 0);

    // Up mode, CCR0=3, undivided SMCLK.
    TASSEL = 2; SMCLKen = 1; TAxCCR0 = 3; MC = 1;
    for (int i = 1; i <= 5; i++) begin
      nextCycle();
      checkOutput("up_TAR", TAR, i % 4);
      checkOutput("up_wTAIFG", wTAIFG, (i >= 4) ? 1 : 0);
    end
    checkOutput("up_TAcount", TAcount, 1);

    // Up/down with CCR0=2.
    MC = 3; TAxCCR0 = 2; TACLR = 1; TAIFGwr = 1; TAIFGwdata = 0;
    nextCycle();
    clearStrobes();
    checkOutput("updn_clr_TAR", TAR, 0);
    checkOutput("updn_clr_wTAIFG", wTAIFG, 0);
    expT = '{1, 2, 1, 0, 1};
    expD = '{0, 1, 1, 0, 0};
    expF = '{0, 0, 0, 1, 1};
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      checkOutput("updn_TAR", TAR, expT[i]);
      checkOutput("updn_TAdir", TAdir, expD[i]);
      checkOutput("updn_wTAIFG", wTAIFG, expF[i]);
    end

    // Continuous with /4 then /3: one count per 12 ticks, FFFF wraps to 0 and sets TAIFG.
    MC = 2; ID = 2; TAIDEX = 2; TACLR = 1; TAIFGwr = 1; TAIFGwdata = 0;
    nextCycle();
    clearStrobes();
    for (int i = 1; i <= 12; i++) begin
      nextCycle();
      checkOutput("div12_TAR", TAR, (i == 12) ? 1 : 0);
    end
    TARwrite = 1; TARin = 16'hFFFF;
    nextCycle();
    TARwrite = 0;
    checkOutput("div12_write", TAR, 16'hFFFF);
    for (int i = 1; i <= 11; i++) nextCycle();
    checkOutput("div12_wrap_TAR", TAR, 0);
    checkOutput("div12_wrap_wTAIFG", wTAIFG, 1);

    // Hardware set beats a simultaneous clear; clear alone then drops the flag.
    MC = 0; ID = 0; TAIDEX = 0; TACLR = 1; TAIFGwr = 1; TAIFGwdata = 0;
    nextCycle();
    clearStrobes();
    TARwrite = 1; TARin = 16'hFFFF;
    nextCycle();
    TARwrite = 0; MC = 2; TAIFGclr = 1;
    nextCycle();
    checkOutput("setclr_TAR", TAR, 0);
    checkOutput("setclr_wTAIFG", wTAIFG, 1);
    MC = 0;
    nextCycle();
    TAIFGclr = 0;
    checkOutput("clr_wTAIFG", wTAIFG, 0);

    // CCR0 lowered below TAR in up mode, then TACLR beating a TAR write.
    MC = 1; TAxCCR0 = 10; TARwrite = 1; TARin = 5;
    nextCycle();
    TARwrite = 0; TAxCCR0 = 2;
    checkOutput("lower_write", TAR, 5);
    nextCycle();
    checkOutput("lower_TAR", TAR, 0);
    checkOutput("lower_wTAIFG", wTAIFG, 1);
    TACLR = 1; TARwrite = 1; TARin = 9;
    nextCycle();
    clearStrobes();
    checkOutput("clrwr_TAR", TAR, 0);
    checkOutput("clrwr_TAcount", TAcount, 0);
    checkOutput("clrwr_wTAIFG", wTAIFG, 1);

    // CCR0=0 holds TAR at zero without a count strobe.
    TAxCCR0 = 0; TARwrite = 1; TARin = 6;
    nextCycle();
    TARwrite = 0;
    nextCycle();
    checkOutput("ccr0zero_TAR", TAR, 0);
    checkOutput("ccr0zero_TAcount", TAcount, 0);

    // Asynchronous reset in the middle of a down-count.
    MC = 3; TAxCCR0 = 8; TARwrite = 1; TARin = 7; TAIFGwr = 1; TAIFGwdata = 1;
    nextCycle();
    clearStrobes();
    nextCycle();
    nextCycle();
    SMCLKen = 0;
    checkOutput("pre_rst_TAR", TAR, 7);
    checkOutput("pre_rst_TAdir", TAdir, 1);
    #1 reset = 1;
    #1;
    checkOutput("async_rst_TAR", TAR, 0);
    checkOutput("async_rst_TAdir", TAdir, 0);
    checkOutput("async_rst_wTAIFG", wTAIFG, 0);
    nextCycle();
    reset = 0;

    for (int n = 0; n < 3000; n++) begin
      applyStimulus();
      nextCycle();
    end

    cmpEn = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
